// File: rtl/bus_receiver_if.sv
// bus_receiver_if: bundles the shared data bus, its driver enable, and the
// downstream FIFO drain handshake for bus_receiver.
//   master modport: bus driver / consumer side (drives bus, enable, ready, clear)
//   slave  modport: bus_receiver side (drives FIFO head, status and count)
interface bus_receiver_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_bus;
  logic             data_en;
  logic             rd_ready;
  logic             ovf_clr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output data_bus, data_en, rd_ready, ovf_clr,
    input  rd_data, rd_valid, full, count, overflow
  );

  modport slave (
    input  data_bus, data_en, rd_ready, ovf_clr,
    output rd_data, rd_valid, full, count, overflow
  );
endinterface

// File: rtl/bus_receiver.sv
// bus_receiver: receiving end of the tri-state data bus. Samples data_bus on
// the first cycle of each data_en window and queues the word in a show-ahead
// FIFO drained by a valid/ready handshake.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - bus_receiver_if.slave:
//            data_bus/data_en : shared bus and driver enable
//            rd_ready         : consumer takes head word this cycle
//            ovf_clr          : clears sticky overflow
//            rd_data/rd_valid : FIFO head word and non-empty flag
//            full/count       : occupancy status
//            overflow         : sticky, a capture was dropped while full
module bus_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  bus_receiver_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             r_en_q;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_capture;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Only the first cycle of an enable window captures; bus contents outside
  // the window never reach any register.
  assign w_capture = bus.data_en & ~r_en_q;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid & bus.rd_ready;
  // A pop on the same edge frees a slot, so a capture while full still lands.
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_q   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_en_q <= bus.data_en;
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.data_bus;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.rd_data  = r_mem[r_rd_ptr];
  assign bus.rd_valid = w_valid;
  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_bus_receiver.sv
module tb_bus_receiver;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_miss = 0;

  bus_receiver_if #(.WIDTH(8), .DEPTH(4)) bif ();

  bus_receiver #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle enable window followed by one idle cycle with a floating bus.
  task automatic window(input logic [7:0] val);
    bif.data_bus = val;
    bif.data_en  = 1'b1;
    tick();
    bif.data_en  = 1'b0;
    bif.data_bus = 'x;
    tick();
  endtask

  initial begin
    logic [7:0] v;
    rst          = 1'b1;
    bif.data_bus = 8'h00;
    bif.data_en  = 1'b0;
    bif.rd_ready = 1'b0;
    bif.ovf_clr  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(bif.count), 0);
    chk("rst_valid", 32'(bif.rd_valid), 0);
    chk("rst_data", 32'(bif.rd_data), 0);
    chk("rst_ovf", 32'(bif.overflow), 0);
    chk("rst_full", 32'(bif.full), 0);

    // Single 3-cycle window: one capture only.
    bif.data_bus = 8'h55;
    bif.data_en  = 1'b1;
    tick();
    chk("single_valid", 32'(bif.rd_valid), 1);
    chk("single_data", 32'(bif.rd_data), 32'h55);
    chk("single_count", 32'(bif.count), 1);
    tick();
    tick();
    chk("single_hold_count", 32'(bif.count), 1);
    bif.data_en  = 1'b0;
    bif.data_bus = 'x;
    tick();
    bif.rd_ready = 1'b1;
    tick();
    chk("single_pop_valid", 32'(bif.rd_valid), 0);
    bif.rd_ready = 1'b0;

    // Ordering and drain.
    window(8'h55);
    window(8'hAA);
    window(8'h0F);
    chk("ord_count", 32'(bif.count), 3);
    bif.rd_ready = 1'b1;
    chk("ord_0", 32'(bif.rd_data), 32'h55);
    tick();
    chk("ord_1", 32'(bif.rd_data), 32'hAA);
    tick();
    chk("ord_2", 32'(bif.rd_data), 32'h0F);
    tick();
    chk("ord_empty", 32'(bif.rd_valid), 0);
    bif.rd_ready = 1'b0;

    // Full and overflow.
    for (int i = 1; i <= 4; i++) window(8'(i));
    chk("full_flag", 32'(bif.full), 1);
    chk("full_count", 32'(bif.count), 4);
    chk("full_no_ovf", 32'(bif.overflow), 0);
    window(8'h05);
    chk("drop_ovf", 32'(bif.overflow), 1);
    chk("drop_count", 32'(bif.count), 4);
    chk("drop_head", 32'(bif.rd_data), 32'h01);
    bif.rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_full", 32'(bif.rd_data), 32'(i));
      tick();
    end
    chk("drain_empty", 32'(bif.rd_valid), 0);
    chk("drain_notfull", 32'(bif.full), 0);
    chk("ovf_sticky", 32'(bif.overflow), 1);
    bif.rd_ready = 1'b0;
    bif.ovf_clr  = 1'b1;
    tick();
    bif.ovf_clr  = 1'b0;
    chk("ovf_cleared", 32'(bif.overflow), 0);

    // Simultaneous push/pop while full.
    for (int i = 1; i <= 4; i++) window(8'(i));
    bif.data_bus = 8'h99;
    bif.data_en  = 1'b1;
    bif.rd_ready = 1'b1;
    tick();
    bif.data_en  = 1'b0;
    bif.data_bus = 'x;
    chk("pp_count", 32'(bif.count), 4);
    chk("pp_ovf", 32'(bif.overflow), 0);
    chk("pp_head", 32'(bif.rd_data), 32'h02);
    chk("pp_r1", 32'(bif.rd_data), 32'h02);
    tick();
    chk("pp_r2", 32'(bif.rd_data), 32'h03);
    tick();
    chk("pp_r3", 32'(bif.rd_data), 32'h04);
    tick();
    chk("pp_r4", 32'(bif.rd_data), 32'h99);
    tick();
    chk("pp_empty", 32'(bif.rd_valid), 0);
    bif.rd_ready = 1'b0;

    // Drop and clear on the same edge: drop wins.
    for (int i = 0; i < 4; i++) window(8'h11 + 8'(i));
    bif.data_bus = 8'h15;
    bif.data_en  = 1'b1;
    bif.ovf_clr  = 1'b1;
    tick();
    bif.data_en  = 1'b0;
    bif.data_bus = 'x;
    chk("drop_vs_clr", 32'(bif.overflow), 1);
    tick();
    bif.ovf_clr = 1'b0;
    chk("clr_after", 32'(bif.overflow), 0);
    window(8'h16);
    chk("drop_again", 32'(bif.overflow), 1);

    // Asynchronous reset mid-operation, enable window spanning release.
    rst          = 1'b1;
    bif.data_en  = 1'b1;
    bif.data_bus = 8'h77;
    #1;
    chk("arst_valid", 32'(bif.rd_valid), 0);
    chk("arst_count", 32'(bif.count), 0);
    chk("arst_data", 32'(bif.rd_data), 0);
    chk("arst_ovf", 32'(bif.overflow), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_count", 32'(bif.count), 1);
    chk("rel_data", 32'(bif.rd_data), 32'h77);
    bif.data_en  = 1'b0;
    bif.data_bus = 'x;
    tick();
    chk("rel_hold", 32'(bif.count), 1);
    bif.rd_ready = 1'b1;
    tick();
    chk("rel_empty", 32'(bif.rd_valid), 0);
    bif.rd_ready = 1'b0;

    // Wrap-around with floating bus between windows.
    for (int i = 0; i < 10; i++) begin
      v = 8'h23 + 8'(i * 8'h1D);
      bif.data_bus = v;
      bif.data_en  = 1'b1;
      bif.rd_ready = 1'b0;
      tick();
      chk("wrap_data", 32'(bif.rd_data), 32'(v));
      chk("wrap_count", 32'(bif.count), 1);
      bif.data_en  = 1'b0;
      bif.data_bus = 'x;
      bif.rd_ready = 1'b1;
      tick();
      chk("wrap_empty", 32'(bif.count), 0);
    end
    bif.rd_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
